// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: widths, opcodes,
// sequencer state encoding and small opcode classification helpers.
package alu_defs;

  localparam int ALU_W = 4;
  localparam int OP_W  = 3;

  localparam logic [OP_W-1:0] OP_SUB = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_AND = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } seq_state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_AND);
  endfunction

  // Only the arithmetic ops produce a meaningful overflow flag.
  function automatic logic op_has_ov(input logic [OP_W-1:0] op);
    return (op == OP_SUB) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the sequencer, with a slave view
// for the sequencer and a master view for the controller plus ALU side.
interface alu_cmd_sequencer_if #(
  parameter int CNT_W = 8
);
  import alu_defs::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ALU_W-1:0]  cmd_a;
  logic [ALU_W-1:0]  cmd_b;

  logic [ALU_W-1:0]  alu_a;
  logic [ALU_W-1:0]  alu_b;
  logic [OP_W-1:0]   alu_OpCode;
  logic [ALU_W-1:0]  alu_r;
  logic              alu_OVFlag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ALU_W-1:0]  rsp_r;
  logic              rsp_ov;
  logic              rsp_err;
  logic              rsp_mismatch;
  logic [CNT_W-1:0]  mismatch_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  alu_r, alu_OVFlag,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_OpCode,
    output rsp_valid, rsp_r, rsp_ov, rsp_err, rsp_mismatch, mismatch_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output alu_r, alu_OVFlag,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_OpCode,
    input  rsp_valid, rsp_r, rsp_ov, rsp_err, rsp_mismatch, mismatch_count
  );

endinterface

// File: rtl/alu_cmd_sequencer_ref_model.sv
// Combinational reference for the 4-bit ALU: expected result, expected
// carry/borrow and opcode legality.
module alu_ref_model
  import alu_defs::*;
(
  input  logic [OP_W-1:0]  i_op,
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  output logic [ALU_W-1:0] o_exp_r,
  output logic             o_exp_ov,
  output logic             o_legal
);

  logic [ALU_W:0] w_wide;

  // One extra bit carries the ADD carry or the SUB borrow.
  always_comb begin
    w_wide  = '0;
    o_legal = 1'b1;
    case (i_op)
      OP_SUB:  w_wide = {1'b0, i_a} - {1'b0, i_b};
      OP_ADD:  w_wide = {1'b0, i_a} + {1'b0, i_b};
      OP_NOT:  w_wide = {1'b0, ~i_a};
      OP_OR:   w_wide = {1'b0, i_a | i_b};
      OP_AND:  w_wide = {1'b0, i_a & i_b};
      default: begin
        w_wide  = '0;
        o_legal = 1'b0;
      end
    endcase
    o_exp_r  = w_wide[ALU_W-1:0];
    o_exp_ov = w_wide[ALU_W];
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequencer that drives the combinational ALU, lets it settle, captures and
// checks its result, and returns it over a valid/ready response channel.
module alu_cmd_sequencer
  import alu_defs::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input logic               clk,
  input logic               rst_n,
  alu_cmd_sequencer_if.slave bus
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  seq_state_e        r_state, w_state_nxt;
  logic [3:0]        r_settle_cnt, w_settle_cnt_nxt;
  logic              r_illegal, w_illegal_nxt;
  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic [ALU_W-1:0]  r_alu_a, w_alu_a_nxt;
  logic [ALU_W-1:0]  r_alu_b, w_alu_b_nxt;
  logic [OP_W-1:0]   r_alu_op, w_alu_op_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [ALU_W-1:0]  r_rsp_r, w_rsp_r_nxt;
  logic              r_rsp_ov, w_rsp_ov_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              r_rsp_mismatch, w_rsp_mismatch_nxt;
  logic [CNT_W-1:0]  r_mismatch_count, w_mismatch_count_nxt;

  logic              w_accept;
  logic              w_rsp_hs;
  logic [ALU_W-1:0]  w_exp_r;
  logic              w_exp_ov;
  logic              w_exp_legal;
  logic              w_mismatch;

  assign w_accept = bus.cmd_valid & r_cmd_ready;
  assign w_rsp_hs = r_rsp_valid & bus.rsp_ready;

  alu_ref_model u_ref (
    .i_op     (r_alu_op),
    .i_a      (r_alu_a),
    .i_b      (r_alu_b),
    .o_exp_r  (w_exp_r),
    .o_exp_ov (w_exp_ov),
    .o_legal  (w_exp_legal)
  );

  // Overflow is only meaningful (and only compared) for SUB and ADD.
  assign w_mismatch = (bus.alu_r != w_exp_r) |
                      (op_has_ov(r_alu_op) & (bus.alu_OVFlag != w_exp_ov));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; illegal ops skip settling and pass through CAPTURE
  // only to line the error response up one cycle after the accept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = op_is_legal(bus.cmd_op) ? ST_SETTLE : ST_CAPTURE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt == 4'd0) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_CAPTURE: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    w_cmd_ready_nxt      = (w_state_nxt == ST_IDLE);
    w_settle_cnt_nxt     = r_settle_cnt;
    w_illegal_nxt        = r_illegal;
    w_alu_a_nxt          = r_alu_a;
    w_alu_b_nxt          = r_alu_b;
    w_alu_op_nxt         = r_alu_op;
    w_rsp_valid_nxt      = r_rsp_valid;
    w_rsp_r_nxt          = r_rsp_r;
    w_rsp_ov_nxt         = r_rsp_ov;
    w_rsp_err_nxt        = r_rsp_err;
    w_rsp_mismatch_nxt   = r_rsp_mismatch;
    w_mismatch_count_nxt = r_mismatch_count;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && op_is_legal(bus.cmd_op)) begin
          w_alu_a_nxt      = bus.cmd_a;
          w_alu_b_nxt      = bus.cmd_b;
          w_alu_op_nxt     = bus.cmd_op;
          w_settle_cnt_nxt = SETTLE_LOAD;
          w_illegal_nxt    = 1'b0;
        end else if (w_accept) begin
          w_illegal_nxt    = 1'b1;
        end else begin
          w_illegal_nxt    = r_illegal;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt != 4'd0) begin
          w_settle_cnt_nxt = r_settle_cnt - 4'd1;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt;
        end
      end
      ST_CAPTURE: begin
        w_rsp_valid_nxt = 1'b1;
        if (r_illegal || !w_exp_legal) begin
          w_rsp_r_nxt        = 4'd0;
          w_rsp_ov_nxt       = 1'b0;
          w_rsp_err_nxt      = 1'b1;
          w_rsp_mismatch_nxt = 1'b0;
        end else begin
          w_rsp_r_nxt        = bus.alu_r;
          w_rsp_ov_nxt       = op_has_ov(r_alu_op) ? bus.alu_OVFlag : 1'b0;
          w_rsp_err_nxt      = 1'b0;
          w_rsp_mismatch_nxt = w_mismatch;
          if (w_mismatch && (r_mismatch_count != CNT_MAX)) begin
            w_mismatch_count_nxt = r_mismatch_count + CNT_W'(1);
          end else begin
            w_mismatch_count_nxt = r_mismatch_count;
          end
        end
      end
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_rsp_valid_nxt = 1'b0;
        end else begin
          w_rsp_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset clears every visible output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd_ready      <= 1'b0;
      r_settle_cnt     <= 4'd0;
      r_illegal        <= 1'b0;
      r_alu_a          <= '0;
      r_alu_b          <= '0;
      r_alu_op         <= '0;
      r_rsp_valid      <= 1'b0;
      r_rsp_r          <= '0;
      r_rsp_ov         <= 1'b0;
      r_rsp_err        <= 1'b0;
      r_rsp_mismatch   <= 1'b0;
      r_mismatch_count <= '0;
    end else begin
      r_cmd_ready      <= w_cmd_ready_nxt;
      r_settle_cnt     <= w_settle_cnt_nxt;
      r_illegal        <= w_illegal_nxt;
      r_alu_a          <= w_alu_a_nxt;
      r_alu_b          <= w_alu_b_nxt;
      r_alu_op         <= w_alu_op_nxt;
      r_rsp_valid      <= w_rsp_valid_nxt;
      r_rsp_r          <= w_rsp_r_nxt;
      r_rsp_ov         <= w_rsp_ov_nxt;
      r_rsp_err        <= w_rsp_err_nxt;
      r_rsp_mismatch   <= w_rsp_mismatch_nxt;
      r_mismatch_count <= w_mismatch_count_nxt;
    end
  end

  assign bus.cmd_ready      = r_cmd_ready;
  assign bus.alu_a          = r_alu_a;
  assign bus.alu_b          = r_alu_b;
  assign bus.alu_OpCode     = r_alu_op;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_r          = r_rsp_r;
  assign bus.rsp_ov         = r_rsp_ov;
  assign bus.rsp_err        = r_rsp_err;
  assign bus.rsp_mismatch   = r_rsp_mismatch;
  assign bus.mismatch_count = r_mismatch_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: a driver queues expected responses from an arithmetic
// reference, a monitor checks each response, its latency and its stability.
module tb_alu_cmd_sequencer;
  import alu_defs::*;

  localparam int SETTLE = 2;
  localparam int CW     = 2;
  localparam int CMAX   = (1 << CW) - 1;

  typedef struct {
    int r;
    int ov;
    int err;
    int mm;
    int cnt;
    int acc;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  int   last_a = 0, last_b = 0, last_op = 0;
  logic fault_en = 1'b0;
  logic [3:0] fault_r = 4'd0;
  logic junk_ov = 1'b0;
  logic rnd_ready = 1'b0;
  logic prev_valid = 1'b0;
  logic [4:0] alu_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_sequencer_if #(.CNT_W(CW)) bus ();

  alu_cmd_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in for the real ALU, with fault injection on r and a random
  // overflow flag for ops that do not define one.
  always_comb begin
    case (bus.alu_OpCode)
      OP_SUB:  alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      OP_ADD:  alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OP_NOT:  alu_t = {junk_ov, ~bus.alu_a};
      OP_OR:   alu_t = {junk_ov, bus.alu_a | bus.alu_b};
      OP_AND:  alu_t = {junk_ov, bus.alu_a & bus.alu_b};
      default: alu_t = {junk_ov, 4'd0};
    endcase
    bus.alu_r      = fault_en ? fault_r : alu_t[3:0];
    bus.alu_OVFlag = alu_t[4];
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) bus.rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void ref_calc(input int op, input int a, input int b,
                                   output int r, output int ov);
    r = 0;
    ov = 0;
    case (op)
      0: begin r = (a - b + 16) % 16; ov = (a < b) ? 1 : 0; end
      1: begin r = (a + b) % 16;      ov = (a + b > 15) ? 1 : 0; end
      2: r = 15 - a;
      3: r = a | b;
      4: r = a & b;
      default: r = 0;
    endcase
  endfunction

  // Monitor: latency on the rising response, stability while stalled,
  // full comparison at the handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          if (!prev_valid) chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
          chk("cmd_ready_in_resp", int'(bus.cmd_ready), 0);
          chk("rsp_r", int'(bus.rsp_r), exp_q[0].r);
          chk("rsp_ov", int'(bus.rsp_ov), exp_q[0].ov);
          chk("rsp_err", int'(bus.rsp_err), exp_q[0].err);
          chk("rsp_mismatch", int'(bus.rsp_mismatch), exp_q[0].mm);
          chk("mismatch_count", int'(bus.mismatch_count), exp_q[0].cnt);
          if (bus.rsp_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid <= bus.rsp_valid;
    end
  end

  task automatic send_cmd(input int op, input int a, input int b, input bit flt);
    exp_t e;
    int   n;
    int   r, ov;
    ref_calc(op, a, b, r, ov);
    junk_ov = 1'($urandom_range(0, 1));
    e.err = (op > 4) ? 1 : 0;
    e.lat = (op > 4) ? 1 : SETTLE + 1;
    e.mm  = 0;
    if (op > 4) begin
      e.r  = 0;
      e.ov = 0;
    end else begin
      e.r  = r;
      e.ov = ov;
      last_a = a; last_b = b; last_op = op;
      if (flt) begin
        fault_r  = 4'(r ^ $urandom_range(1, 15));
        fault_en = 1'b1;
        e.r  = int'(fault_r);
        e.mm = 1;
        if (model_cnt < CMAX) model_cnt++;
      end
    end
    e.cnt = model_cnt;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_a     = 4'(a);
    bus.cmd_b     = 4'(b);
    n = 0;
    while (!bus.cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      chk("accept_timeout", n, 0);
    end else begin
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", n, 0);
    @(posedge clk);
    #1 fault_en = 1'b0;
  endtask

  task automatic do_cmd(input int op, input int a, input int b, input bit flt);
    send_cmd(op, a, b, flt);
    wait_drain();
  endtask

  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd1;
    bus.cmd_a     = 4'd3;
    bus.cmd_b     = 4'd4;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_outputs", int'({bus.alu_a, bus.alu_b, bus.alu_OpCode, bus.rsp_r,
        bus.rsp_ov, bus.rsp_err, bus.rsp_mismatch}), 0);
    chk("rst_count", int'(bus.mismatch_count), 0);
    rst_n = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(bus.cmd_ready), 1);
    chk("no_accept_in_rst", int'(bus.alu_OpCode), 0);

    bus.rsp_ready = 1'b1;
    for (int op = 0; op < 5; op++) do_cmd(op, 8, 7, 1'b0);
    do_cmd(0, 10, 12, 1'b0);
    do_cmd(1, 10, 12, 1'b0);
    do_cmd(4, 15, 15, 1'b0);

    do_cmd(6, 5, 9, 1'b0);
    chk("illegal_keeps_op", int'(bus.alu_OpCode), last_op);
    chk("illegal_keeps_a", int'(bus.alu_a), last_a);
    chk("illegal_keeps_b", int'(bus.alu_b), last_b);

    bus.rsp_ready = 1'b0;
    send_cmd(1, 9, 9, 1'b0);
    repeat (SETTLE + 7) @(negedge clk);
    chk("bp_still_pending", exp_q.size(), 1);
    bus.rsp_ready = 1'b1;
    wait_drain();

    do_cmd(1, 6, 3, 1'b1);

    send_cmd(3, 2, 5, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    fault_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_settle_valid", int'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_rsp_after_abort", int'(bus.rsp_valid), 0);
    end
    chk("ready_after_abort", int'(bus.cmd_ready), 1);
    chk("count_after_abort", int'(bus.mismatch_count), 0);

    for (int i = 0; i < 5; i++) do_cmd(i % 2, $urandom_range(0, 15), $urandom_range(0, 15), 1'b1);

    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_cmd($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
             ($urandom_range(0, 7) == 0));
    end
    rnd_ready = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
